// File: rtl/mem_sequencer.sv
// mem_sequencer: shares one req/ready memory bus between the core's
// instruction fetch and its data load/store. The core is held through
// halt_o and released for exactly one cycle per instruction. The block
// also produces the register write-back strobe, a retired-instruction
// counter and a bus watchdog.
module mem_sequencer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] fetch_addr,
    input  logic        d_req,
    input  logic [31:0] mem_addr,
    input  logic        mem_we,
    input  logic [1:0]  mem_byte_sel,
    input  logic [31:0] mem_wdata,
    input  logic        ext_halt_i,
    output logic [31:0] inst_o,
    output logic [31:0] mem_rdata_o,
    output logic        halt_o,
    output logic        wb_en_o,
    output logic [31:0] instret_o,
    output logic        err_o,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready
);

    typedef enum logic [2:0] {
        S_RESET,
        S_FETCH,
        S_ISSUE,
        S_EXEC,
        S_DATA,
        S_ERR
    } state_t;

    // Watchdog fires in the cycle where the counter already holds
    // TIMEOUT-1 waiting cycles and the bus is still not ready, so an
    // error is raised after exactly TIMEOUT unanswered request cycles.
    localparam bit             WDOG_EN    = (TIMEOUT != 0);
    localparam logic [7:0]     WDOG_LIMIT = WDOG_EN ? 8'(TIMEOUT - 1) : 8'd0;

    state_t      state;
    state_t      next_state;
    logic [31:0] inst_q;
    logic [31:0] rdata_q;
    logic        first_q;
    logic [7:0]  wdog;
    logic        err_q;
    logic [31:0] instret_q;
    logic        in_bus;
    logic        timeout;

    assign in_bus      = (state == S_FETCH) || (state == S_DATA);
    assign timeout     = WDOG_EN && in_bus && !bus_ready && (wdog == WDOG_LIMIT);
    assign inst_o      = inst_q;
    assign mem_rdata_o = rdata_q;
    assign instret_o   = instret_q;
    assign err_o       = err_q;

    // State register; reset drops the bus request immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RESET;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus the bus and core-control outputs.
    always_comb begin
        next_state = state;
        halt_o     = 1'b1;
        wb_en_o    = 1'b0;
        bus_req    = 1'b0;
        bus_addr   = 32'd0;
        bus_we     = 1'b0;
        bus_size   = 2'b10;
        bus_wdata  = 32'd0;
        case (state)
            S_RESET: begin
                next_state = S_FETCH;
            end
            S_FETCH: begin
                bus_req  = 1'b1;
                bus_addr = fetch_addr;
                if (bus_ready) begin
                    next_state = S_ISSUE;
                end else if (timeout) begin
                    next_state = S_ERR;
                end
            end
            S_ISSUE: begin
                halt_o     = 1'b0;
                wb_en_o    = !first_q;
                next_state = S_EXEC;
            end
            S_EXEC: begin
                if (!ext_halt_i) begin
                    next_state = d_req ? S_DATA : S_FETCH;
                end
            end
            S_DATA: begin
                bus_req   = 1'b1;
                bus_addr  = mem_addr;
                bus_we    = mem_we;
                bus_size  = mem_byte_sel;
                bus_wdata = mem_wdata;
                if (bus_ready) begin
                    next_state = S_FETCH;
                end else if (timeout) begin
                    next_state = S_ERR;
                end
            end
            S_ERR: begin
                next_state = S_ERR;
            end
            default: begin
                next_state = S_RESET;
            end
        endcase
    end

    // Watchdog counts unanswered request cycles within one bus phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog <= 8'd0;
        end else if (!in_bus || bus_ready || (next_state != state)) begin
            wdog <= 8'd0;
        end else begin
            wdog <= wdog + 8'd1;
        end
    end

    // Holding registers for the fetched instruction and load data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q  <= 32'h0000_0013;
            rdata_q <= 32'd0;
        end else begin
            if ((state == S_FETCH) && bus_ready) begin
                inst_q <= bus_rdata;
            end
            if ((state == S_DATA) && bus_ready && !mem_we) begin
                rdata_q <= bus_rdata;
            end
        end
    end

    // Retirement bookkeeping; the first issue after reset is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q   <= 1'b1;
            instret_q <= 32'd0;
        end else if (state == S_ISSUE) begin
            first_q <= 1'b0;
            if (!first_q) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    // Sticky bus-timeout error, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_sequencer.sv
// tb_mem_sequencer: drives mem_sequencer like a simple core, answers the
// bus with a latency-programmable memory model and compares every
// completed bus transaction against a queue of expected transactions.
module tb_mem_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] fetch_addr;
    logic        d_req;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [1:0]  mem_byte_sel;
    logic [31:0] mem_wdata;
    logic        ext_halt_i;
    logic [31:0] inst_o;
    logic [31:0] mem_rdata_o;
    logic        halt_o;
    logic        wb_en_o;
    logic [31:0] instret_o;
    logic        err_o;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [1:0]  bus_size;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [1:0]  size;
        logic [31:0] wdata;
    } txn_t;

    txn_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   lat          = 0;
    bit   hang         = 1'b0;
    int   wait_cnt     = 0;
    int   write_count  = 0;

    mem_sequencer #(.TIMEOUT(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_addr   (fetch_addr),
        .d_req        (d_req),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_byte_sel (mem_byte_sel),
        .mem_wdata    (mem_wdata),
        .ext_halt_i   (ext_halt_i),
        .inst_o       (inst_o),
        .mem_rdata_o  (mem_rdata_o),
        .halt_o       (halt_o),
        .wb_en_o      (wb_en_o),
        .instret_o    (instret_o),
        .err_o        (err_o),
        .bus_req      (bus_req),
        .bus_addr     (bus_addr),
        .bus_we       (bus_we),
        .bus_size     (bus_size),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .bus_ready    (bus_ready)
    );

    always #5 clk = ~clk;

    // Memory contents: fixed words at 0 and 0x100, address-derived elsewhere.
    function automatic logic [31:0] memVal(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0093;
        if (a == 32'h100) return 32'hDEAD_BEEF;
        return {a[29:0], 2'b11};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic pushTxn(input logic [31:0] a, input logic we, input logic [1:0] sz, input logic [31:0] wd);
        txn_t t;
        t.addr  = a;
        t.we    = we;
        t.size  = sz;
        t.wdata = wd;
        exp_q.push_back(t);
    endtask

    // Sets the core's view of the instruction just issued and queues the bus traffic it should cause.
    task automatic applyStimulus(input logic [31:0] next_pc, input logic dr, input logic we,
                                 input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                                 input bit expect_bus);
        fetch_addr   = next_pc;
        d_req        = dr;
        mem_we       = we;
        mem_byte_sel = sz;
        mem_addr     = a;
        mem_wdata    = wd;
        if (expect_bus) begin
            if (dr) pushTxn(a, we, sz, wd);
            pushTxn(next_pc, 1'b0, 2'b10, 32'd0);
        end
    endtask

    // Waits for the next single-cycle issue slot, bounded.
    task automatic waitIssue(input string tag, output int cycles, output int data_cycles);
        cycles      = 0;
        data_cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (bus_req && d_req && (bus_addr == mem_addr)) data_cycles++;
        end while (halt_o && cycles < 200);
        checkOutput({tag, "_issue_seen"}, {31'd0, halt_o}, 32'd0);
    endtask

    // Bus responder: asserts ready after lat waiting cycles and scores each completion.
    always @(negedge clk) begin
        if (rst_n && bus_req && !hang && wait_cnt >= lat) begin
            bus_ready = 1'b1;
            bus_rdata = memVal(bus_addr);
            checkOutput("txn_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                txn_t e;
                e = exp_q.pop_front();
                checkOutput("txn_addr", bus_addr, e.addr);
                checkOutput("txn_we", {31'd0, bus_we}, {31'd0, e.we});
                checkOutput("txn_size", {30'd0, bus_size}, {30'd0, e.size});
                if (e.we) checkOutput("txn_wdata", bus_wdata, e.wdata);
            end
            if (bus_we) write_count++;
            wait_cnt = 0;
        end else begin
            bus_ready = 1'b0;
            bus_rdata = 32'h0BAD_0BAD;
            wait_cnt  = (rst_n && bus_req) ? wait_cnt + 1 : 0;
        end
    end

    initial begin
        int cyc;
        int dcyc;
        int n;
        int wc0;
        bit bad;
        rst_n        = 1'b0;
        fetch_addr   = 32'd0;
        d_req        = 1'b0;
        mem_addr     = 32'd0;
        mem_we       = 1'b0;
        mem_byte_sel = 2'b10;
        mem_wdata    = 32'd0;
        ext_halt_i   = 1'b0;
        bus_ready    = 1'b0;
        bus_rdata    = 32'd0;

        repeat (3) @(negedge clk);
        checkOutput("rst_halt", {31'd0, halt_o}, 32'd1);
        checkOutput("rst_bus_req", {31'd0, bus_req}, 32'd0);
        checkOutput("rst_wb_en", {31'd0, wb_en_o}, 32'd0);
        checkOutput("rst_inst", inst_o, 32'h0000_0013);
        checkOutput("rst_rdata", mem_rdata_o, 32'd0);
        checkOutput("rst_instret", instret_o, 32'd0);
        checkOutput("rst_err", {31'd0, err_o}, 32'd0);

        // First fetch from address 0 with zero-wait memory.
        pushTxn(32'd0, 1'b0, 2'b10, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("fetch0_req", {31'd0, bus_req}, 32'd1);
        checkOutput("fetch0_addr", bus_addr, 32'd0);
        @(negedge clk);
        checkOutput("issue0_halt", {31'd0, halt_o}, 32'd0);
        checkOutput("issue0_inst", inst_o, 32'h0000_0093);
        checkOutput("issue0_wb_en", {31'd0, wb_en_o}, 32'd0);
        @(negedge clk);
        checkOutput("issue0_instret", instret_o, 32'd0);

        // ALU instruction: next issue retires it, period of 3 cycles.
        applyStimulus(32'd4, 1'b0, 1'b0, 2'b10, 32'd0, 32'd0, 1'b1);
        waitIssue("alu", cyc, dcyc);
        checkOutput("alu_period", cyc + 1, 32'd3);
        checkOutput("alu_inst", inst_o, memVal(32'd4));
        checkOutput("alu_wb_en", {31'd0, wb_en_o}, 32'd1);
        @(negedge clk);
        checkOutput("alu_instret", instret_o, 32'd1);

        // Load at 0x100 with 4 wait cycles.
        lat = 4;
        applyStimulus(32'd8, 1'b1, 1'b0, 2'b10, 32'h100, 32'd0, 1'b1);
        waitIssue("load", cyc, dcyc);
        checkOutput("load_data_cycles", dcyc, 32'd5);
        checkOutput("load_rdata", mem_rdata_o, 32'hDEAD_BEEF);
        checkOutput("load_wb_en", {31'd0, wb_en_o}, 32'd1);
        checkOutput("load_inst", inst_o, memVal(32'd8));
        @(negedge clk);
        checkOutput("load_instret", instret_o, 32'd2);

        // Byte store at 0x204: one bus write, load data unchanged, CPI 4.
        lat = 0;
        wc0 = write_count;
        applyStimulus(32'd12, 1'b1, 1'b1, 2'b00, 32'h204, 32'h0000_00AB, 1'b1);
        waitIssue("store", cyc, dcyc);
        checkOutput("store_period", cyc + 1, 32'd4);
        checkOutput("store_writes", write_count - wc0, 32'd1);
        checkOutput("store_rdata_kept", mem_rdata_o, 32'hDEAD_BEEF);
        @(negedge clk);
        checkOutput("store_instret", instret_o, 32'd3);

        // Debug hold in EXEC for 10 cycles, then resume.
        ext_halt_i = 1'b1;
        applyStimulus(32'd16, 1'b0, 1'b0, 2'b10, 32'd0, 32'd0, 1'b1);
        n   = 0;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_req) n++;
            if (!halt_o) bad = 1'b1;
        end
        checkOutput("hold_no_req", n, 32'd0);
        checkOutput("hold_halted", {31'd0, bad}, 32'd0);
        ext_halt_i = 1'b0;
        waitIssue("resume", cyc, dcyc);
        checkOutput("resume_inst", inst_o, memVal(32'd16));
        @(negedge clk);
        checkOutput("resume_instret", instret_o, 32'd4);

        // Reset asserted in the middle of a hung data access.
        hang = 1'b1;
        applyStimulus(32'd20, 1'b1, 1'b0, 2'b10, 32'h300, 32'd0, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus_req && bus_addr == 32'h300) && n < 20);
        checkOutput("midreset_data_req", {31'd0, bus_req}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_req_drop", {31'd0, bus_req}, 32'd0);
        checkOutput("midreset_halt", {31'd0, halt_o}, 32'd1);
        checkOutput("midreset_instret", instret_o, 32'd0);
        hang = 1'b0;
        applyStimulus(32'd0, 1'b0, 1'b0, 2'b10, 32'd0, 32'd0, 1'b0);
        pushTxn(32'd0, 1'b0, 2'b10, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        waitIssue("restart", cyc, dcyc);
        checkOutput("restart_inst", inst_o, 32'h0000_0093);
        checkOutput("restart_wb_en", {31'd0, wb_en_o}, 32'd0);
        @(negedge clk);

        // Fetch that never completes trips the watchdog after 8 request cycles.
        hang = 1'b1;
        applyStimulus(32'h40, 1'b0, 1'b0, 2'b10, 32'd0, 32'd0, 1'b0);
        n   = 0;
        cyc = 0;
        while (cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (err_o) break;
            if (bus_req) n++;
        end
        checkOutput("wdog_err", {31'd0, err_o}, 32'd1);
        checkOutput("wdog_req_cycles", n, 32'd8);
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus_req || !halt_o || !err_o) bad = 1'b1;
        end
        checkOutput("err_terminal", {31'd0, bad}, 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("err_cleared", {31'd0, err_o}, 32'd0);
        hang = 1'b0;
        @(negedge clk);

        checkOutput("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
